// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_draw_arbiter
// Description : Shares the single VGA pixel-write port among several sprite
//               drawers. Requester 0 (screen clear) has fixed top priority;
//               requesters 1..N_REQ-1 rotate round-robin. A winner owns the
//               port for a whole transaction, ended by done or by dropping
//               req. Off-screen pixels are suppressed.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               req, done               - per-requester request / end pulse
//               x_in, y_in, colour_in   - packed per-requester pixel data
//               plot_in                 - per-requester pixel write enable
//               gnt, busy               - registered one-hot grant, |gnt
//               x_out, y_out,
//               colour_out, plot_out    - registered pixel to vga_adapter
//               timeout_err             - 1-cycle watchdog revoke pulse
// Options     : VGA_DRAW_ARBITER_WATCHDOG_EN - revoke grants held for
//               MAX_GRANT_CYCLES cycles; otherwise timeout_err is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_draw_arbiter #(
    parameter int N_REQ            = 4,
    parameter int X_SCREEN_PIXELS  = 160,
    parameter int Y_SCREEN_PIXELS  = 120,
    parameter int MAX_GRANT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [8*N_REQ-1:0]   x_in,
    input  logic [7*N_REQ-1:0]   y_in,
    input  logic [3*N_REQ-1:0]   colour_in,
    input  logic [N_REQ-1:0]     plot_in,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic [7:0]           x_out,
    output logic [6:0]           y_out,
    output logic [2:0]           colour_out,
    output logic                 plot_out,
    output logic                 timeout_err
);

    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] c_gnt_lsb = N_REQ'(1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_grant   = 2'd1;
    localparam logic [1:0] c_release = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_idx_w-1:0]  r_sel;
    logic [c_idx_w-1:0]  r_last;
    logic [c_idx_w-1:0]  w_winner;
    logic                w_found;
    int                  w_idx;
    logic [N_REQ-1:0]    r_gnt;
    logic [7:0]          r_x;
    logic [6:0]          r_y;
    logic [2:0]          r_col;
    logic                r_plot;
    logic [7:0]          w_x;
    logic [6:0]          w_y;
    logic [2:0]          w_col;
    logic                w_plot_ok;
    logic                w_end_grant;
    logic                w_wd_expire;

    // Winner selection: requester 0 first, then a rotating search over
    // 1..N_REQ-1 that starts just after the last winner. r_last == 0 (a
    // clear was last served) naturally starts the search at 1.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        if (!req[0]) begin
            for (int k = 0; k < N_REQ - 1; k++) begin
                w_idx = int'(r_last) + 1 + k;
                if (w_idx > N_REQ - 1) begin
                    w_idx = w_idx - (N_REQ - 1);
                end
                if (!w_found && req[c_idx_w'(w_idx)]) begin
                    w_found  = 1'b1;
                    w_winner = c_idx_w'(w_idx);
                end
            end
        end
    end

    // Selected requester's pixel and end-of-transaction condition
    assign w_x   = x_in[8*int'(r_sel) +: 8];
    assign w_y   = y_in[7*int'(r_sel) +: 7];
    assign w_col = colour_in[3*int'(r_sel) +: 3];
    assign w_plot_ok = plot_in[r_sel]
                     & (int'(w_x) < X_SCREEN_PIXELS)
                     & (int'(w_y) < Y_SCREEN_PIXELS);
    assign w_end_grant = done[r_sel] | ~req[r_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:    if (|req) w_state_nxt = c_grant;
            c_grant:   if (w_end_grant || w_wd_expire) w_state_nxt = c_release;
            c_release: w_state_nxt = c_idle;
            default:   w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt  <= '0;
            r_sel  <= '0;
            r_last <= c_idx_w'(N_REQ - 1);
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
            r_plot <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_plot <= 1'b0;
                    if (|req) begin
                        r_sel <= w_winner;
                        r_gnt <= c_gnt_lsb << w_winner;
                    end
                end
                c_grant: begin
                    // The pixel presented alongside done is still written.
                    r_x    <= w_x;
                    r_y    <= w_y;
                    r_col  <= w_col;
                    r_plot <= w_plot_ok;
                    if (w_end_grant || w_wd_expire) begin
                        r_gnt  <= '0;
                        r_last <= r_sel;
                    end
                end
                default: begin
                    // Release: the final pixel stays visible for this cycle
                    r_gnt  <= '0;
                    r_plot <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_DRAW_ARBITER_WATCHDOG_EN
    localparam logic [15:0] c_wd_limit = 16'(MAX_GRANT_CYCLES - 1);

    logic [15:0] r_wd_cnt;
    logic        r_timeout;

    // Counter is held at 0 outside GRANT, so it starts from 0 on entry.
    assign w_wd_expire = (r_state == c_grant) && (r_wd_cnt == c_wd_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_expire && !w_end_grant;
            if (r_state == c_grant) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign timeout_err = 1'b0;

    // The watchdog limit only matters when the watchdog is built; an
    // out-of-range value elaborates to nothing here.
    if (MAX_GRANT_CYCLES < 2) begin : g_wd_limit_unused
    end
`endif

    assign gnt        = r_gnt;
    assign busy       = |r_gnt;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign colour_out = r_col;
    assign plot_out   = r_plot;

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_draw_arbiter
// Description : Table-driven bench for vga_draw_arbiter. Each vector gives
//               the inputs for one cycle and the outputs expected after the
//               following clock edge. Non-selected slices carry distinct
//               background pixels so a wrong slice selection shows up.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_draw_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [11:0] colour_in;
    logic [3:0]  plot_in;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot_out;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    vga_draw_arbiter #(
        .N_REQ            (4),
        .X_SCREEN_PIXELS  (160),
        .Y_SCREEN_PIXELS  (120),
        .MAX_GRANT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .x_in        (x_in),
        .y_in        (y_in),
        .colour_in   (colour_in),
        .plot_in     (plot_in),
        .gnt         (gnt),
        .busy        (busy),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour_out  (colour_out),
        .plot_out    (plot_out),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        int         pidx;     // slice carrying the test pixel, -1 = none
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic       pp;
        logic [3:0] e_gnt;
        logic       e_plot;
        logic       e_to;
        logic       chk;      // also compare x/y/colour
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] rq,
                                input logic [3:0] dn, input int pidx,
                                input int px, input int py, input int pc,
                                input logic pp, input logic [3:0] e_gnt,
                                input logic e_plot, input logic e_to,
                                input logic chk, input int ex, input int ey,
                                input int ec);
        vec_t v;
        v.rst = rst;      v.req = rq;       v.done = dn;    v.pidx = pidx;
        v.px = 8'(px);    v.py = 7'(py);    v.pc = 3'(pc);  v.pp = pp;
        v.e_gnt = e_gnt;  v.e_plot = e_plot; v.e_to = e_to; v.chk = chk;
        v.e_x = 8'(ex);   v.e_y = 7'(ey);   v.e_c = 3'(ec);
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        reset = v.rst;
        req   = v.req;
        done  = v.done;
        for (int i = 0; i < 4; i++) begin
            x_in[8*i +: 8]      = 8'(10 + i);
            y_in[7*i +: 7]      = 7'(20 + i);
            colour_in[3*i +: 3] = 3'(i);
            plot_in[i]          = 1'b1;
        end
        if (v.pidx >= 0) begin
            x_in[8*v.pidx +: 8]      = v.px;
            y_in[7*v.pidx +: 7]      = v.py;
            colour_in[3*v.pidx +: 3] = v.pc;
            plot_in[v.pidx]          = v.pp;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (gnt !== v.e_gnt) begin
            n_err++;
            $display("FAIL %s gnt: got %b want %b", tag, gnt, v.e_gnt);
        end
        if (busy !== (|v.e_gnt)) begin
            n_err++;
            $display("FAIL %s busy: got %b want %b", tag, busy, |v.e_gnt);
        end
        if (plot_out !== v.e_plot) begin
            n_err++;
            $display("FAIL %s plot_out: got %b want %b", tag, plot_out, v.e_plot);
        end
        if (timeout_err !== v.e_to) begin
            n_err++;
            $display("FAIL %s timeout_err: got %b want %b", tag, timeout_err, v.e_to);
        end
        if (v.chk && (x_out !== v.e_x || y_out !== v.e_y || colour_out !== v.e_c)) begin
            n_err++;
            $display("FAIL %s pixel: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     tag, x_out, y_out, colour_out, v.e_x, v.e_y, v.e_c);
        end
    endtask

    vec_t vt[24];

    initial begin
        reset = 1'b1; req = '0; done = '0;
        x_in = '0; y_in = '0; colour_in = '0; plot_in = '0;
        repeat (2) @(posedge clk);
        #1;

        //             rst  req      done     pidx  px   py  pc pp  gnt      plt to chk ex   ey  ec
        // single grant, bounds on x and y, pixel written alongside done
        vt[0]  = mk(0, 4'b0010, 4'b0000, -1,    0,   0, 0, 0, 4'b0010, 0, 0, 0,   0,   0, 0);
        vt[1]  = mk(0, 4'b0010, 4'b0000,  1,   50, 105, 7, 1, 4'b0010, 1, 0, 1,  50, 105, 7);
        vt[2]  = mk(0, 4'b0010, 4'b0000,  1,  160,  10, 5, 1, 4'b0010, 0, 0, 1, 160,  10, 5);
        vt[3]  = mk(0, 4'b0010, 4'b0010,  1,  159, 119, 2, 1, 4'b0000, 1, 0, 1, 159, 119, 2);
        vt[4]  = mk(0, 4'b0000, 4'b0000, -1,    0,   0, 0, 0, 4'b0000, 0, 0, 0,   0,   0, 0);
        // reset, then rotation 1,2,3,1 with three pixels each
        vt[5]  = mk(1, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b0000, 0, 0, 1,   0,   0, 0);
        vt[6]  = mk(0, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b0010, 0, 0, 0,   0,   0, 0);
        vt[7]  = mk(0, 4'b1110, 4'b0000,  1,    1,   1, 1, 1, 4'b0010, 1, 0, 1,   1,   1, 1);
        vt[8]  = mk(0, 4'b1110, 4'b1100,  1,    2,   2, 2, 1, 4'b0010, 1, 0, 1,   2,   2, 2);
        vt[9]  = mk(0, 4'b1110, 4'b0010,  1,    3,   3, 3, 1, 4'b0000, 1, 0, 1,   3,   3, 3);
        vt[10] = mk(0, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b0000, 0, 0, 0,   0,   0, 0);
        vt[11] = mk(0, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b0100, 0, 0, 0,   0,   0, 0);
        vt[12] = mk(0, 4'b1110, 4'b0000,  2,    4,   4, 4, 1, 4'b0100, 1, 0, 1,   4,   4, 4);
        vt[13] = mk(0, 4'b1110, 4'b0000,  2,    5,   5, 5, 0, 4'b0100, 0, 0, 1,   5,   5, 5);
        vt[14] = mk(0, 4'b1110, 4'b0100,  2,    6,   6, 6, 1, 4'b0000, 1, 0, 1,   6,   6, 6);
        vt[15] = mk(0, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b0000, 0, 0, 0,   0,   0, 0);
        vt[16] = mk(0, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b1000, 0, 0, 0,   0,   0, 0);
        vt[17] = mk(0, 4'b1110, 4'b0000,  3,    7,   7, 7, 1, 4'b1000, 1, 0, 1,   7,   7, 7);
        vt[18] = mk(0, 4'b1110, 4'b0000,  3,    8,   8, 0, 1, 4'b1000, 1, 0, 1,   8,   8, 0);
        vt[19] = mk(0, 4'b1110, 4'b1000,  3,    9,   9, 1, 1, 4'b0000, 1, 0, 1,   9,   9, 1);
        vt[20] = mk(0, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b0000, 0, 0, 0,   0,   0, 0);
        vt[21] = mk(0, 4'b1110, 4'b0000, -1,    0,   0, 0, 0, 4'b0010, 0, 0, 0,   0,   0, 0);
        // dropping req ends the grant just like done
        vt[22] = mk(0, 4'b1100, 4'b0000,  1,   12,  13, 6, 0, 4'b0000, 0, 0, 1,  12,  13, 6);
        vt[23] = mk(0, 4'b0000, 4'b0000, -1,    0,   0, 0, 0, 4'b0000, 0, 0, 0,   0,   0, 0);

        // reset state
        apply_vec(mk(1, 4'b0000, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0), "reset");

        for (int i = 0; i < 24; i++) begin
            apply_vec(vt[i], $sformatf("tbl[%0d]", i));
        end

        // No preemption: req[0] rises while requester 2 holds the port and
        // is served ahead of pending 1 and 3; afterwards rotation resumes at 1.
        apply_vec(mk(1, 4'b0000, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0), "pre_rst");
        apply_vec(mk(0, 4'b0100, 4'b0000, -1, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0), "pre_g2");
        apply_vec(mk(0, 4'b1111, 4'b0000, -1, 0, 0, 0, 0, 4'b0100, 1, 0, 1, 12, 22, 2), "pre_hold0");
        apply_vec(mk(0, 4'b1111, 4'b0000, -1, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 0), "pre_hold1");
        apply_vec(mk(0, 4'b1111, 4'b0100, -1, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0), "pre_done2");
        apply_vec(mk(0, 4'b1011, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0), "pre_rel");
        apply_vec(mk(0, 4'b1011, 4'b0000, -1, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0), "pre_g0");
        apply_vec(mk(0, 4'b1011, 4'b0001, -1, 0, 0, 0, 0, 4'b0000, 1, 0, 1, 10, 20, 0), "pre_done0");
        apply_vec(mk(0, 4'b1010, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0), "pre_rel0");
        apply_vec(mk(0, 4'b1010, 4'b0000, -1, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0), "pre_g1");

        // Reset while requester 3 is plotting: in-flight pixel dropped and
        // the rotation restarts at requester 1.
        apply_vec(mk(1, 4'b0000, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0), "rst_a");
        apply_vec(mk(0, 4'b1000, 4'b0000, -1, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 0), "rst_g3");
        apply_vec(mk(0, 4'b1000, 4'b0000,  3, 20, 30, 4, 1, 4'b1000, 1, 0, 1, 20, 30, 4), "rst_px");
        apply_vec(mk(1, 4'b1000, 4'b0000,  3, 21, 31, 5, 1, 4'b0000, 0, 0, 1, 0, 0, 0), "rst_mid");
        apply_vec(mk(0, 4'b1010, 4'b0000, -1, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0), "rst_g1");

`ifdef VGA_DRAW_ARBITER_WATCHDOG_EN
        // Requester 1 never pulses done: revoked after 8 GRANT cycles.
        apply_vec(mk(1, 4'b0000, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0), "wd_rst");
        apply_vec(mk(0, 4'b0110, 4'b0000, -1, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0), "wd_g1");
        for (int i = 0; i < 7; i++) begin
            apply_vec(mk(0, 4'b0110, 4'b0000, -1, 0, 0, 0, 0, 4'b0010, 1, 0, 0, 0, 0, 0),
                      $sformatf("wd_hold[%0d]", i));
        end
        apply_vec(mk(0, 4'b0110, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 0, 0), "wd_revoke");
        apply_vec(mk(0, 4'b0110, 4'b0000, -1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0), "wd_idle");
        apply_vec(mk(0, 4'b0110, 4'b0000, -1, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0), "wd_g2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
